// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// The slow scan clock is synchronised and edge-detected on clk. Each tick
// advances one digit, blanks all anodes for BLANK_CYCLES clocks, then shows
// the digit. A shadow copy of the display inputs is taken once per frame,
// so a frame never mixes old and new data.
`timescale 1ns/1ps
module seg7_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_clk,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero;
  // the rightmost digit is always shown so a zero value still reads "0".
  function automatic logic is_leading_zero(input logic [1:0] k, input logic [15:0] v);
    logic z;
    case (k)
      2'd3:    z = (v[15:12] == 4'h0);
      2'd2:    z = (v[15:8] == 8'h00);
      2'd1:    z = (v[15:4] == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  // Nibble for digit k.
  function automatic logic [3:0] pick_nibble(input logic [1:0] k, input logic [15:0] v);
    logic [3:0] n;
    case (k)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      2'd3:    n = v[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        hist_q, hist_d;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] shadow_value_q, shadow_value_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [3:0]  shadow_en_q, shadow_en_d;
  logic        shadow_lz_q, shadow_lz_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_done_q, frame_done_d;

  logic        tick;
  logic        digit_dark;

  assign tick = sync2_q & ~hist_q;

  // State register: every flop of the block, async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      hist_q         <= 1'b0;
      state_q        <= ST_BLANK;
      cnt_q          <= 8'd0;
      idx_q          <= 2'd3;
      shadow_value_q <= 16'h0000;
      shadow_dp_q    <= 4'h0;
      shadow_en_q    <= 4'h0;
      shadow_lz_q    <= 1'b0;
      an_q           <= 4'b1111;
      seg_q          <= 7'h7F;
      dp_q           <= 1'b1;
      frame_done_q   <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      hist_q         <= hist_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_en_q    <= shadow_en_d;
      shadow_lz_q    <= shadow_lz_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Next-state: scan synchroniser, digit index, blank counter and FSM state.
  always_comb begin
    sync1_d = scan_clk;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (tick) begin
      idx_d   = idx_q + 2'd1;
      cnt_d   = BLANK_LOAD;
      state_d = ST_BLANK;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          state_d = ST_SHOW;
        end
        default: begin
          state_d = ST_BLANK;
        end
      endcase
    end
  end

  // Dark slot: digit disabled or suppressed as a leading zero.
  always_comb begin
    if (!shadow_en_q[idx_q]) begin
      digit_dark = 1'b1;
    end else if (shadow_lz_q && is_leading_zero(idx_q, shadow_value_q)) begin
      digit_dark = 1'b1;
    end else begin
      digit_dark = 1'b0;
    end
  end

  // Outputs and frame shadow: blank on tick, load digit when blank expires.
  always_comb begin
    an_d           = an_q;
    seg_d          = seg_q;
    dp_d           = dp_q;
    frame_done_d   = 1'b0;
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_en_d    = shadow_en_q;
    shadow_lz_d    = shadow_lz_q;
    if (tick) begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (idx_q == 2'd3) begin
        shadow_value_d = value;
        shadow_dp_d    = dp_in;
        shadow_en_d    = digit_en;
        shadow_lz_d    = blank_lz;
        frame_done_d   = 1'b1;
      end else begin
        frame_done_d   = 1'b0;
      end
    end else if ((state_q == ST_BLANK) && (cnt_q == 8'd0)) begin
      if (digit_dark) begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end else begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = hex_to_seg(pick_nibble(idx_q, shadow_value_q));
        dp_d  = ~shadow_dp_q[idx_q];
      end
    end else begin
      an_d  = an_q;
      seg_d = seg_q;
      dp_d  = dp_q;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (default blank and a one-cycle
// blank) share stimulus; a frame-level model predicts every output cycle,
// and directed steps pin literal digit patterns.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic        scan_clk;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, fd0, fd1;

  int errors = 0;
  int checks = 0;
  int fd_count = 0;
  int fd_base;

  seg7_scan_driver u_dut (
    .clk(clk), .reset(reset), .scan_clk(scan_clk), .value(value),
    .dp_in(dp_in), .digit_en(digit_en), .blank_lz(blank_lz),
    .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0)
  );

  seg7_scan_driver #(.BLANK_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .scan_clk(scan_clk), .value(value),
    .dp_in(dp_in), .digit_en(digit_en), .blank_lz(blank_lz),
    .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Frame-level model: edge counter, pending tick edges, current digit and
  // the frame snapshot.
  int          m_cyc;
  int          m_last;
  int          m_idx;
  bit          m_ticked;
  bit          m_wrap;
  logic        m_sc_prev;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_en;
  logic        m_lz;
  int          tick_q[$];

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_cyc = 0; m_last = 0; m_idx = 3; m_ticked = 0; m_wrap = 0;
        m_sc_prev = 1'b0; m_val = 16'h0; m_dp = 4'h0; m_en = 4'h0; m_lz = 1'b0;
        tick_q.delete();
      end else begin
        m_cyc++;
        if (tick_q.size() > 0 && tick_q[0] == m_cyc) begin
          void'(tick_q.pop_front());
          m_idx = (m_idx + 1) % 4;
          m_ticked = 1;
          m_last = m_cyc;
          m_wrap = (m_idx == 0);
          if (m_wrap) begin
            m_val = value; m_dp = dp_in; m_en = digit_en; m_lz = blank_lz;
          end
        end
        // A rise first seen on this edge acts two edges later.
        if (scan_clk && !m_sc_prev) tick_q.push_back(m_cyc + 2);
        m_sc_prev = scan_clk;
      end
    end
  end

  // Expected {an,seg,dp} for an instance whose blank lasts 'blank' cycles.
  function automatic logic [11:0] model_out(input int blank);
    logic [3:0] nib;
    logic       off;
    nib = 4'((m_val >> (4 * m_idx)) & 16'h000F);
    off = !m_ticked || ((m_cyc - m_last) < blank) || !m_en[m_idx] ||
          (m_lz && (m_idx != 0) && ((m_val >> (4 * m_idx)) == 16'h0000));
    if (off) return {4'b1111, 7'h7F, 1'b1};
    return {~(4'b0001 << m_idx), hex7(nib), ~m_dp[m_idx]};
  endfunction

  // Per-cycle comparison of both instances against the model.
  initial begin
    logic [11:0] e0, e1;
    logic        efd;
    forever begin
      @(negedge clk);
      e0  = model_out(16);
      e1  = model_out(1);
      efd = m_ticked && (m_cyc == m_last) && m_wrap;
      chk("model_out_b16", {20'h0, an0, seg0, dp0}, {20'h0, e0});
      chk("model_out_b1",  {20'h0, an1, seg1, dp1}, {20'h0, e1});
      chk("model_fd_b16",  {31'h0, fd0}, {31'h0, efd});
      chk("model_fd_b1",   {31'h0, fd1}, {31'h0, efd});
      if (fd0) fd_count++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_digit();
    scan_clk = 1'b1;
    cycles(25);
    scan_clk = 1'b0;
    cycles(25);
  endtask

  task automatic chk_digit(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
    chk({name, "_an"},  {28'h0, an0}, {28'h0, a});
    chk({name, "_seg"}, {25'h0, seg0}, {25'h0, s});
    chk({name, "_dp"},  {31'h0, dp0}, {31'h0, d});
  endtask

  initial begin
    reset = 1'b0; scan_clk = 1'b0; value = 16'h0; dp_in = 4'h0;
    digit_en = 4'h0; blank_lz = 1'b0;
    cycles(5);
    chk_digit("in_reset", 4'b1111, 7'h7F, 1'b1);
    reset = 1'b1;
    cycles(1000);
    chk_digit("idle_after_reset", 4'b1111, 7'h7F, 1'b1);
    chk("idle_fd", {31'h0, fd0}, 32'h0);

    // One full frame of 12AF.
    value = 16'h12AF; dp_in = 4'b0100; digit_en = 4'b1111; blank_lz = 1'b0;
    fd_base = fd_count;
    step_digit(); chk_digit("f1_d0", 4'b1110, 7'b0001110, 1'b1);
    step_digit(); chk_digit("f1_d1", 4'b1101, 7'b0001000, 1'b1);
    step_digit(); chk_digit("f1_d2", 4'b1011, 7'b0100100, 1'b0);
    step_digit(); chk_digit("f1_d3", 4'b0111, 7'b1111001, 1'b1);
    chk("f1_fd_pulses", fd_count - fd_base, 32'd1);

    // Blank timing: rise driven just after edge k, dark from edge k+3.
    scan_clk = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycles(1);
      if (i <= 2) chk("pre_tick_an", {28'h0, an0}, 32'h7);
      else if (i <= 18) chk("blank16_an", {28'h0, an0}, 32'hF);
      else if (i == 19) chk("blank16_end_an", {28'h0, an0}, 32'hE);
      else chk("blank16_hold_an", {28'h0, an0}, 32'hE);
      if (i == 3) chk("blank1_an", {28'h0, an1}, 32'hF);
      else if (i == 4) chk("blank1_end_an", {28'h0, an1}, 32'hE);
      else begin end
    end
    cycles(10);
    scan_clk = 1'b0;
    cycles(25);

    // Leading-zero suppression; finishing the 12AF frame shows no tearing.
    value = 16'h0005; blank_lz = 1'b1;
    step_digit(); chk_digit("tear_d1", 4'b1101, 7'b0001000, 1'b1);
    step_digit(); step_digit();
    step_digit(); chk_digit("lz5_d0", 4'b1110, 7'b0010010, 1'b1);
    step_digit(); chk_digit("lz5_d1", 4'b1111, 7'h7F, 1'b1);
    step_digit(); chk_digit("lz5_d2", 4'b1111, 7'h7F, 1'b1);
    value = 16'h0000;
    step_digit(); chk_digit("lz5_d3", 4'b1111, 7'h7F, 1'b1);
    step_digit(); chk_digit("lz0_d0", 4'b1110, 7'b1000000, 1'b1);
    step_digit(); chk_digit("lz0_d1", 4'b1111, 7'h7F, 1'b1);
    step_digit(); step_digit();
    value = 16'h0A00;
    step_digit(); chk_digit("lzA_d0", 4'b1110, 7'b1000000, 1'b1);
    step_digit(); chk_digit("lzA_d1", 4'b1101, 7'b1000000, 1'b1);
    step_digit(); chk_digit("lzA_d2", 4'b1011, 7'b0001000, 1'b0);
    step_digit(); chk_digit("lzA_d3", 4'b1111, 7'h7F, 1'b1);

    // Mid-frame value change waits for the next frame boundary.
    value = 16'h1111; blank_lz = 1'b0;
    step_digit(); chk_digit("v1_d0", 4'b1110, 7'b1111001, 1'b1);
    step_digit(); chk_digit("v1_d1", 4'b1101, 7'b1111001, 1'b1);
    value = 16'h2222;
    step_digit(); chk_digit("v1_d2", 4'b1011, 7'b1111001, 1'b0);
    step_digit(); chk_digit("v1_d3", 4'b0111, 7'b1111001, 1'b1);
    step_digit(); chk_digit("v2_d0", 4'b1110, 7'b0100100, 1'b1);

    // Asynchronous reset while digit 2 is showing.
    step_digit();
    step_digit(); chk_digit("pre_rst_d2", 4'b1011, 7'b0100100, 1'b0);
    value = 16'hABCD;
    reset = 1'b0;
    #1;
    chk_digit("async_rst", 4'b1111, 7'h7F, 1'b1);
    cycles(3);
    reset = 1'b1;
    cycles(20);
    chk_digit("post_rst_idle", 4'b1111, 7'h7F, 1'b1);
    fd_base = fd_count;
    step_digit(); chk_digit("post_rst_d0", 4'b1110, 7'b0100001, 1'b1);
    chk("post_rst_fd", fd_count - fd_base, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Four-digit, multiplexed seven-segment display driver. It consumes the ~250 Hz divided clock from the clock divider stage and advances one digit per rising edge of that clock. All logic runs on the 50 MHz system clock; the slow clock is treated as a data input and edge-detected. A 16-bit hex value is shadowed once per frame, decoded, optionally leading-zero suppressed and driven to active-low anode and segment pins, with an anti-ghosting blank between digits.

Parameters:
BLANK_CYCLES, 16, number of clk cycles all anodes are held off after each scan tick; legal range 1..255.

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset
scan_clk  input  1  ~250 Hz divided clock from the clock divider; asynchronous to this block's logic
value  input  16  hex value to display; [15:12] is digit 3 (leftmost), [3:0] is digit 0
dp_in  input  4  decimal point request per digit, 1 = lit
digit_en  input  4  per-digit enable, 0 = digit always dark
blank_lz  input  1  1 = suppress leading zeros
an  output  4  anode drives, active-low, an[k] selects digit k
seg  output  7  segment drives, active-low, {g,f,e,d,c,b,a}
dp  output  1  decimal point drive, active-low
frame_done  output  1  one-cycle pulse at each frame boundary (shadow load)

Behaviour:
- Reset (reset=0, async): an=4'b1111, seg=7'b1111111, dp=1, frame_done=0, digit index=3, state=BLANK with counter=0, shadow regs=0, synchroniser flops=0.
- scan_clk passes through a 2-flop synchroniser, then through one history flop. tick = sync2 & ~hist. tick is asserted exactly one clk cycle per scan_clk rising edge, 3 clk edges after the edge arrives.
- All outputs are registered.
- States: BLANK, SHOW.
- On tick, from either state:
  - idx <= idx+1 mod 4.
  - an <= 4'b1111, seg <= 7'h7F, dp <= 1.
  - counter <= BLANK_CYCLES-1; state <= BLANK.
  - A tick arriving during BLANK restarts the blank.
- If the tick wraps idx from 3 to 0:
  - shadow_value, shadow_dp, shadow_en and shadow_lz load from the inputs on that edge.
  - frame_done=1 for that one cycle.
  - Because reset sets idx=3, the first tick after reset is a frame boundary.
- BLANK with no tick:
  - If counter≠0, counter decrements.
  - If counter=0, state <= SHOW and outputs load the current digit. Anodes are therefore dark for exactly BLANK_CYCLES cycles after the tick edge.
- SHOW: outputs hold until the next tick.
- Digit drive in SHOW, for nibble n = shadow_value[4*idx+3:4*idx]:
  - seg = hex decode of n, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - dp = ~shadow_dp[idx].
  - an[idx] = 0 unless the digit is dark. All other anodes stay 1.
  - Dark digit: shadow_en[idx]=0, or the digit is suppressed. A dark digit still uses its time slot, with an=1111, seg=7'h7F, dp=1.
- Leading-zero suppression (shadow_lz=1):
  - Digit k (k=3,2,1) is suppressed iff its nibble and every higher nibble are 0.
  - Digit 0 is never suppressed.
  - dp_in has no effect on suppression.
- Inputs changing mid-frame: no visible effect until the next frame boundary. No tearing within a frame.
- scan_clk held constant: the current state and outputs hold indefinitely.
- Reset mid-SHOW: outputs go dark immediately (async). Scanning resumes from digit 0 on the first tick after release.

Test Plan:
- Reset, then reset release with scan_clk static -> an=1111, seg=7F, dp=1, frame_done=0, held for 1000 cycles.
- value=16'h12AF, dp_in=0100, digit_en=1111, blank_lz=0, 4 scan_clk rising edges -> digit 0 shows seg=0001110 (F), dp=1 (decimal point dark); digit 1 shows 0001000 (A); digit 2 shows 0100100 (2), dp=0 (lit); digit 3 shows 1111001 (1). frame_done pulses once at the digit 0 tick. Each an value is one-hot-low.
- scan_clk rises at time t -> an=1111 from t+3 clk for exactly 16 cycles (BLANK_CYCLES default), then the digit appears. Repeat with BLANK_CYCLES=1 -> one dark cycle.
- value=16'h0005, blank_lz=1 -> digits 3, 2 and 1 dark (an=1111 during their slots), digit 0 shows 0010010. value=16'h0000 -> only digit 0 lit, showing 1000000. value=16'h0A00 -> digit 3 dark, digit 0 shows 1000000.
- value changed from 16'h1111 to 16'h2222 while digit 1 is showing -> digits 2 and 3 of that frame still show 1. After the next frame_done, all digits show 2.
- Reset asserted during SHOW on digit 2 -> an=1111 asynchronously. After release, the first tick shows digit 0 with a freshly loaded shadow and frame_done=1.
